iana_trace_packer: RTL and testbench

- Parametrised capture stage between the CPU instruction-analysis trace output and the AXI-Stream S2MM DMA input.
- Buffers TRACE_W-bit trace records in an internal FIFO and serialises each record into DATA_W-bit stream beats.
- Frames records into packets of PKT_LEN with tlast, and drives a hysteretic CPU stall request so trace is not lost under DMA backpressure.
- Generalises the fixed 128-bit/32-bit, single-threshold capture path to configurable widths, depth, watermarks and explicit flush.

---
 rtl/iana_trace_packer.sv | 121 ++++++++++++
 tb/tb_iana_trace_packer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iana_trace_packer.sv
// Trace capture packer: buffers TRACE_W-bit trace records in a FIFO, serialises them into
// DATA_W-bit AXI-Stream beats framed into PKT_LEN-record packets, and raises a hysteretic stall.
module iana_trace_packer #(
    parameter int TRACE_W  = 128,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 16,
    parameter int PKT_LEN  = 64,
    parameter int STALL_HI = 12,
    parameter int STALL_LO = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [TRACE_W-1:0]       trace_in,
    input  logic                     trace_valid,
    input  logic                     cfg_enable,
    input  logic                     cfg_stall_en,
    input  logic                     cfg_flush,
    output logic                     stall_req,
    output logic [DATA_W-1:0]        m_tdata,
    output logic [DATA_W/8-1:0]      m_tkeep,
    output logic                     m_tlast,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              drop_count,
    output logic                     overflow
);
    localparam int RATIO = TRACE_W / DATA_W;
    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = AW + 1;
    localparam int BW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int CW    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [TRACE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]      level_q, level_d;
    logic [BW-1:0]      beat_q;
    logic [CW-1:0]      rec_cnt_q;
    logic               flush_pend_q, stall_q, ovf_q;
    logic [15:0]        drop_q;

    logic               valid, hs, last_beat, pop, want, full, push, drop, tlast, tlast_hs;
    logic [TRACE_W-1:0] head;
    logic [DATA_W-1:0]  word;

    assign valid     = (level_q != '0);
    assign hs        = valid & m_tready;
    assign last_beat = (beat_q == BW'(RATIO - 1));
    assign pop       = hs & last_beat;
    assign want      = trace_valid & cfg_enable;
    assign full      = (level_q == LW'(DEPTH));
    // A full FIFO still accepts when the head record leaves in the same cycle.
    assign push      = want & (~full | pop);
    assign drop      = want & full & ~pop;
    assign tlast     = valid & last_beat &
                       ((rec_cnt_q == CW'(PKT_LEN - 1)) | (flush_pend_q & (level_q == LW'(1))));
    assign tlast_hs  = hs & tlast;
    assign head      = mem_q[rd_ptr_q];

    always_comb begin
        word = '0;
        if (valid) word = head[32'(beat_q) * DATA_W +: DATA_W];
    end

    always_comb begin
        level_d = level_q;
        if (push && !pop)      level_d = level_q + LW'(1);
        else if (!push && pop) level_d = level_q - LW'(1);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= trace_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            beat_q       <= '0;
            rec_cnt_q    <= '0;
            flush_pend_q <= 1'b0;
            stall_q      <= 1'b0;
            drop_q       <= '0;
            ovf_q        <= 1'b0;
        end else begin
            level_q <= level_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (hs)   beat_q   <= last_beat ? '0 : beat_q + BW'(1);

            if (tlast_hs)  rec_cnt_q <= '0;
            else if (pop)  rec_cnt_q <= rec_cnt_q + CW'(1);

            // An idle flush with no open packet has nothing to close.
            if (cfg_flush && !(level_q == '0 && rec_cnt_q == '0)) flush_pend_q <= 1'b1;
            else if (tlast_hs)                                     flush_pend_q <= 1'b0;

            if (!cfg_stall_en || level_q <= LW'(STALL_LO)) stall_q <= 1'b0;
            else if (level_q >= LW'(STALL_HI))             stall_q <= 1'b1;

            if (drop) begin
                drop_q <= sat_inc16(drop_q);
                ovf_q  <= 1'b1;
            end
        end
    end

    assign stall_req  = stall_q;
    assign m_tvalid   = valid;
    assign m_tdata    = word;
    assign m_tkeep    = {(DATA_W/8){valid}};
    assign m_tlast    = tlast;
    assign level      = level_q;
    assign drop_count = drop_q;
    assign overflow   = ovf_q;
endmodule

// File: tb/tb_iana_trace_packer.sv
// Bench for iana_trace_packer (PKT_LEN=4): table-driven packets plus hand sequences, with a
// beat scoreboard checking every stream handshake.
module tb_iana_trace_packer;
    localparam int TW = 128;
    localparam int DW = 32;
    localparam int PKT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [TW-1:0] trace_in = '0;
    logic          trace_valid = 1'b0;
    logic          cfg_enable = 1'b1;
    logic          cfg_stall_en = 1'b1;
    logic          cfg_flush = 1'b0;
    logic          stall_req;
    logic [DW-1:0] m_tdata;
    logic [3:0]    m_tkeep;
    logic          m_tlast;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic [4:0]    level;
    logic [15:0]   drop_count;
    logic          overflow;

    iana_trace_packer #(.TRACE_W(TW), .DATA_W(DW), .DEPTH(16), .PKT_LEN(PKT),
                        .STALL_HI(12), .STALL_LO(8)) dut (
        .clk(clk), .rst(rst), .trace_in(trace_in), .trace_valid(trace_valid),
        .cfg_enable(cfg_enable), .cfg_stall_en(cfg_stall_en), .cfg_flush(cfg_flush),
        .stall_req(stall_req), .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .level(level),
        .drop_count(drop_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [DW-1:0] data; logic last; } beat_t;
    typedef struct packed { logic [TW-1:0] rec; logic exp_last; } vec_t;

    beat_t exq[$];
    beat_t mon_e;
    int    total = 0;
    int    bad = 0;
    int    sb_cnt = 0;
    int    beats_seen = 0;
    vec_t  tbl [8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (m_tvalid && m_tready) begin
            beats_seen++;
            total++;
            if (exq.size() == 0) begin
                bad++;
                $display("FAIL beat_unexpected got data=%h last=%b", m_tdata, m_tlast);
            end else begin
                mon_e = exq.pop_front();
                if (m_tdata !== mon_e.data || m_tlast !== mon_e.last || m_tkeep !== 4'hF) begin
                    bad++;
                    $display("FAIL beat got data=%h last=%b keep=%h want data=%h last=%b keep=f",
                             m_tdata, m_tlast, m_tkeep, mon_e.data, mon_e.last);
                end
            end
        end
    end

    function automatic logic [TW-1:0] mk(input int id);
        logic [TW-1:0] r;
        for (int k = 0; k < 4; k++) r[k*32 +: 32] = 32'hC0DE0000 | (32'(id & 255) << 8) | 32'(k);
        return r;
    endfunction

    task automatic sb_push(input logic [TW-1:0] rec, input logic force_last);
        logic lst;
        lst = force_last || (sb_cnt == PKT - 1);
        for (int b = 0; b < 4; b++) exq.push_back({rec[b*32 +: 32], (b == 3) && lst});
        sb_cnt = lst ? 0 : sb_cnt + 1;
    endtask

    task automatic push_rec(input logic [TW-1:0] rec, input logic acc, input logic force_last);
        trace_in    = rec;
        trace_valid = 1'b1;
        if (acc) sb_push(rec, force_last);
        @(posedge clk); #1;
        trace_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exq.delete();
        sb_cnt = 0;
    endtask

    task automatic pulse_flush();
        cfg_flush = 1'b1;
        tick();
        cfg_flush = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exq.size() != 0 || level != 0) && n < 600) begin
            tick();
            n++;
        end
        chk({name, "_drained"}, 32'(exq.size() == 0 && level == 0), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic held_ok;
        int   n;
        for (int i = 0; i < 8; i++) begin
            tbl[i].rec      = mk(16 + i);
            tbl[i].exp_last = (i == 3 || i == 7);
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tvalid", 32'(m_tvalid), 0);
        chk("rst_tlast", 32'(m_tlast), 0);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_tkeep", 32'(m_tkeep), 0);
        chk("rst_stall", 32'(stall_req), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_drop", 32'(drop_count), 0);
        chk("rst_ovf", 32'(overflow), 0);
        rst = 1'b0;

        // 1: single record, beats on consecutive cycles, one cycle after push
        m_tready = 1'b1;
        push_rec({32'd3, 32'd2, 32'd1, 32'd0}, 1'b1, 1'b0);
        for (int b = 0; b < 4; b++) begin
            chk("t1_tvalid", 32'(m_tvalid), 1);
            chk("t1_tdata", m_tdata, 32'(b));
            chk("t1_tkeep", 32'(m_tkeep), 32'hF);
            tick();
        end
        chk("t1_level", 32'(level), 0);
        chk("t1_tvalid_off", 32'(m_tvalid), 0);

        // 2: eight records -> two packets of four, table driven
        reset_dut();
        m_tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            trace_in    = tbl[i].rec;
            trace_valid = 1'b1;
            for (int b = 0; b < 4; b++)
                exq.push_back({tbl[i].rec[b*32 +: 32], (b == 3) && tbl[i].exp_last});
            tick();
        end
        trace_valid = 1'b0;
        wait_drain("t2");

        // 3: stall hysteresis
        reset_dut();
        m_tready = 1'b0;
        for (int i = 0; i < 12; i++) push_rec(mk(40 + i), 1'b1, 1'b0);
        chk("t3_level12", 32'(level), 12);
        chk("t3_stall_lag", 32'(stall_req), 0);
        tick();
        chk("t3_stall_on", 32'(stall_req), 1);
        m_tready = 1'b1;
        held_ok = 1'b1;
        n = 0;
        while (level != 8 && n < 100) begin
            tick();
            n++;
            if (level > 8 && stall_req !== 1'b1) held_ok = 1'b0;
        end
        chk("t3_stall_held", 32'(held_ok), 1);
        chk("t3_reached8", 32'(level), 8);
        chk("t3_stall_at8", 32'(stall_req), 1);
        tick();
        chk("t3_stall_off", 32'(stall_req), 0);
        wait_drain("t3");

        // 5: flush closes a short packet; later packets start fresh
        reset_dut();
        m_tready = 1'b1;
        push_rec(mk(50), 1'b1, 1'b0);
        push_rec(mk(51), 1'b1, 1'b0);
        push_rec(mk(52), 1'b1, 1'b1);
        pulse_flush();
        wait_drain("t5a");
        for (int i = 0; i < 4; i++) push_rec(mk(60 + i), 1'b1, 1'b0);
        wait_drain("t5b");
        push_rec(mk(70), 1'b1, 1'b0);
        push_rec(mk(71), 1'b1, 1'b0);
        wait_drain("t5c");
        pulse_flush();
        push_rec(mk(72), 1'b1, 1'b1);
        wait_drain("t5d");
        pulse_flush();
        push_rec(mk(80), 1'b1, 1'b0);
        wait_drain("t5e");
        for (int i = 1; i < 4; i++) push_rec(mk(80 + i), 1'b1, 1'b0);
        wait_drain("t5f");

        // 4: overflow and drop counting
        reset_dut();
        m_tready = 1'b0;
        for (int i = 0; i < 20; i++) push_rec(mk(90 + i), i < 16, 1'b0);
        chk("t4_level", 32'(level), 16);
        chk("t4_drop", 32'(drop_count), 4);
        chk("t4_ovf", 32'(overflow), 1);
        beats_seen = 0;
        m_tready = 1'b1;
        wait_drain("t4");
        chk("t4_beats", 32'(beats_seen), 64);
        chk("t4_ovf_sticky", 32'(overflow), 1);
        chk("t4_drop_hold", 32'(drop_count), 4);

        // 6: reset in the middle of a record
        push_rec(mk(120), 1'b1, 1'b0);
        chk("t6_beat0", m_tdata, mk(120) >> 0 & 128'hFFFFFFFF);
        tick();
        tick();
        chk("t6_beat2", m_tdata, 32'((mk(120) >> 64) & 128'hFFFFFFFF));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exq.delete();
        sb_cnt = 0;
        chk("t6_tvalid", 32'(m_tvalid), 0);
        chk("t6_level", 32'(level), 0);
        chk("t6_drop", 32'(drop_count), 0);
        chk("t6_ovf", 32'(overflow), 0);
        chk("t6_tlast", 32'(m_tlast), 0);
        push_rec(mk(121), 1'b1, 1'b0);
        chk("t6_post_beat0", m_tdata, 32'(mk(121) & 128'hFFFFFFFF));
        wait_drain("t6");

        chk("final_queue_empty", 32'(exq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
